// File: rtl/i2s_tx_multi.sv
// Parametrised I2S / left-justified / TDM serial audio transmitter.
// One-frame holding register with valid/ready intake and underrun reporting.
module i2s_tx_multi #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 16,
  parameter int NUM_CH   = 2,
  parameter int PRESC_W  = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [PRESC_W-1:0]           prescaler,
  input  logic [1:0]                   mode,
  input  logic                         enable,
  input  logic [NUM_CH*SAMPLE_W-1:0]   sample_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic                         sclk,
  output logic                         lrclk,
  output logic                         sdata,
  output logic                         frame_start,
  output logic                         underrun
);

  localparam int F  = NUM_CH * SLOT_W;
  localparam int BW = $clog2(F);
  localparam logic [BW-1:0] LAST_BIT = BW'(F - 1);
  localparam logic [BW-1:0] HALF_BIT = BW'(F / 2);

  logic [PRESC_W-1:0]         pc_q, pc_d, p_q, p_d, p_new;
  logic [BW-1:0]              bit_q, bit_d, bit_nxt;
  logic                       sclk_q, sclk_d, lrclk_q, lrclk_d, en_q, en_d;
  logic [F-1:0]               shift_q, shift_d, frame_word;
  logic [NUM_CH*SAMPLE_W-1:0] hold_q, hold_d;
  logic                       sample_ready_q, sample_ready_d;
  logic                       frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic                       tick, fall_tick, start, wrap, load;
  logic [SLOT_W-1:0]          slot;

  // Word-select level while bit idx is on the wire; I2S leads LJ by one bit.
  function automatic logic lr_at(input logic [1:0] m, input logic [BW-1:0] idx);
    logic [BW-1:0] nxt;
    nxt = (idx == LAST_BIT) ? '0 : idx + 1'b1;
    case (m)
      2'b01:   return idx >= HALF_BIT;
      2'b10:   return idx == '0;
      default: return nxt >= HALF_BIT;
    endcase
  endfunction

  always_comb begin
    frame_word = '0;
    slot       = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      slot = '0;
      slot[SLOT_W-1 -: SAMPLE_W] = hold_q[(NUM_CH-1-ch)*SAMPLE_W +: SAMPLE_W];
      frame_word[(NUM_CH-1-ch)*SLOT_W +: SLOT_W] = slot;
    end
  end

  always_comb begin
    p_new     = (prescaler == '0) ? PRESC_W'(1) : prescaler;
    tick      = (pc_q == p_q - 1'b1);
    fall_tick = en_q && tick && sclk_q;
    start     = enable && !en_q;
    wrap      = enable && fall_tick && (bit_q == LAST_BIT);
    load      = start || wrap;
    bit_nxt   = bit_q + 1'b1;

    pc_d           = pc_q;
    p_d            = p_q;
    bit_d          = bit_q;
    sclk_d         = sclk_q;
    lrclk_d        = lrclk_q;
    shift_d        = shift_q;
    hold_d         = hold_q;
    sample_ready_d = sample_ready_q;
    en_d           = enable;
    frame_start_d  = 1'b0;
    underrun_d     = 1'b0;

    if (!enable) begin
      pc_d    = '0;
      bit_d   = '0;
      sclk_d  = 1'b0;
      lrclk_d = 1'b0;
      shift_d = '0;
    end else if (load) begin
      pc_d          = '0;
      bit_d         = '0;
      sclk_d        = 1'b0;
      p_d           = p_new;
      shift_d       = sample_ready_q ? '0 : frame_word;
      lrclk_d       = lr_at(mode, '0);
      frame_start_d = 1'b1;
      underrun_d    = sample_ready_q;
    end else if (tick) begin
      pc_d   = '0;
      sclk_d = !sclk_q;
      if (sclk_q) begin
        bit_d   = bit_nxt;
        shift_d = shift_q << 1;
        lrclk_d = lr_at(mode, bit_nxt);
      end
    end else begin
      pc_d = pc_q + 1'b1;
    end

    // Handshake: a word moves when sample_valid && sample_ready at a clk edge;
    // sample_ready is low exactly while the holding register is full.
    if (load && !sample_ready_q) sample_ready_d = 1'b1;
    if (sample_valid && sample_ready_q) begin
      hold_d         = sample_in;
      sample_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q           <= '0;
      p_q            <= PRESC_W'(1);
      bit_q          <= '0;
      sclk_q         <= 1'b0;
      lrclk_q        <= 1'b0;
      en_q           <= 1'b0;
      shift_q        <= '0;
      hold_q         <= '0;
      sample_ready_q <= 1'b1;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      p_q            <= p_d;
      bit_q          <= bit_d;
      sclk_q         <= sclk_d;
      lrclk_q        <= lrclk_d;
      en_q           <= en_d;
      shift_q        <= shift_d;
      hold_q         <= hold_d;
      sample_ready_q <= sample_ready_d;
      frame_start_q  <= frame_start_d;
      underrun_q     <= underrun_d;
    end
  end

  assign sample_ready = sample_ready_q;
  assign sclk         = sclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = shift_q[F-1];
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx_multi.sv
// Bench for i2s_tx_multi: a stereo 16-bit instance and a 4-channel TDM instance,
// checked against a per-clock waveform model derived from frame word, P and mode.
module tb_i2s_tx_multi;

  logic        clk, rst_n;
  logic [7:0]  a_presc, t_presc;
  logic [1:0]  a_mode, t_mode;
  logic        a_en, t_en, a_valid, t_valid;
  logic [31:0] a_din;
  logic [95:0] t_din;
  logic        a_ready, a_sclk, a_lrclk, a_sdata, a_fs, a_ur;
  logic        t_ready, t_sclk, t_lrclk, t_sdata, t_fs, t_ur;

  int n_pass, n_total, errs, rdy_errs;

  logic [31:0]  exp_q[$];
  logic [31:0]  drv_q[$];
  logic [31:0]  inc_d, pend_d, last_word;
  logic [127:0] t_word;
  logic         stream, pend, sb_on, last_ur;

  i2s_tx_multi dut_a (
    .clk(clk), .reset_n(rst_n), .prescaler(a_presc), .mode(a_mode), .enable(a_en),
    .sample_in(a_din), .sample_valid(a_valid), .sample_ready(a_ready),
    .sclk(a_sclk), .lrclk(a_lrclk), .sdata(a_sdata), .frame_start(a_fs), .underrun(a_ur)
  );

  i2s_tx_multi #(.SAMPLE_W(24), .SLOT_W(32), .NUM_CH(4), .PRESC_W(8)) dut_t (
    .clk(clk), .reset_n(rst_n), .prescaler(t_presc), .mode(t_mode), .enable(t_en),
    .sample_in(t_din), .sample_valid(t_valid), .sample_ready(t_ready),
    .sclk(t_sclk), .lrclk(t_lrclk), .sdata(t_sdata), .frame_start(t_fs), .underrun(t_ur)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [4:0] outs(input int d);
    return (d == 0) ? {a_sclk, a_lrclk, a_sdata, a_fs, a_ur}
                    : {t_sclk, t_lrclk, t_sdata, t_fs, t_ur};
  endfunction

  // Word-select rules per format, in terms of bit index b of an f-bit frame.
  function automatic logic lr_model(input logic [1:0] m, input int b, input int f);
    case (m)
      2'b01:   return b >= f / 2;
      2'b10:   return b == 0;
      default: return ((b + 1) % f) >= f / 2;
    endcase
  endfunction

  function automatic logic [127:0] tdm_word(input logic [95:0] din);
    logic [127:0] w;
    w = '0;
    for (int ch = 0; ch < 4; ch++) w[127-32*ch -: 32] = {din[95-24*ch -: 24], 8'h00};
    return w;
  endfunction

  // One clock step: scoreboard for instance A, then drive its intake.
  task automatic tick();
    @(negedge clk);
    if (sb_on) begin
      if (a_fs) begin
        if (exp_q.size() > 0) begin
          last_word = exp_q.pop_front();
          last_ur   = 1'b0;
        end else begin
          last_word = '0;
          last_ur   = 1'b1;
        end
      end
      if (pend) exp_q.push_back(pend_d);
      if (a_ready !== (exp_q.size() == 0)) rdy_errs++;
    end
    pend    = 1'b0;
    a_valid = 1'b0;
    if (a_ready) begin
      if (drv_q.size() > 0) begin
        a_din = drv_q.pop_front(); a_valid = 1'b1; pend = 1'b1; pend_d = a_din;
      end else if (stream) begin
        a_din = inc_d; inc_d = inc_d + 1; a_valid = 1'b1; pend = 1'b1; pend_d = a_din;
      end
    end
    if (stream && !a_valid) begin
      a_valid = 1'b1;
      a_din   = $urandom;
    end
  endtask

  task automatic wait_fs(input int d, input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = outs(d)[1];
    end
    chk({tag, "_seen"}, 128'(seen), 128'(1));
  endtask

  // Called on the negedge just after a load; walks the whole frame.
  task automatic check_frame(input int d, input int p, input string tag, input int chg_k,
                             input int chg_p, input logic [127:0] w_in, input logic ur_in);
    int f, len, werr, b;
    logic [127:0] w, obs;
    logic ur, e_sclk, e_lr, e_sd;
    logic [1:0] m;
    logic [4:0] o;
    f    = (d == 0) ? 32 : 128;
    len  = f * 2 * p;
    werr = 0;
    obs  = '0;
    m    = (d == 0) ? a_mode : t_mode;
    w    = (d == 0) ? {96'b0, last_word} : w_in;
    ur   = (d == 0) ? last_ur : ur_in;
    for (int k = 0; k < len; k++) begin
      if (k > 0) tick();
      if (k == chg_k) a_presc = 8'(chg_p);
      o = outs(d);
      if (k == 0) begin
        chk({tag, "_start"}, 128'(o[1]), 128'(1));
        chk({tag, "_underrun"}, 128'(o[0]), 128'(ur));
      end
      b      = k / (2 * p);
      e_sclk = (k % (2 * p)) >= p;
      e_sd   = w[f-1-b];
      e_lr   = lr_model(m, b, f);
      if (o[4] !== e_sclk || o[3] !== e_lr || o[2] !== e_sd) werr++;
      if (k > 0 && (o[1] !== 1'b0 || o[0] !== 1'b0)) werr++;
      if (k % (2 * p) == p) obs[f-1-b] = o[2];
    end
    chk({tag, "_data"}, obs, w);
    chk({tag, "_wave_errs"}, 128'(werr), 128'(0));
  endtask

  initial begin
    n_pass = 0; n_total = 0; rdy_errs = 0; errs = 0;
    rst_n = 1'b0; a_en = 0; t_en = 0; a_valid = 0; t_valid = 0; a_din = '0; t_din = '0;
    a_presc = 8'd2; t_presc = 8'd0; a_mode = 2'b00; t_mode = 2'b10;
    stream = 0; pend = 0; sb_on = 0; inc_d = $urandom; last_word = '0; last_ur = 0;
    t_word = '0; pend_d = '0;

    // Reset held with toggling inputs
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ({a_sclk, a_lrclk, a_sdata, a_fs, a_ur, a_ready} !== 6'b000001) errs++;
      if ({t_sclk, t_lrclk, t_sdata, t_fs, t_ur, t_ready} !== 6'b000001) errs++;
      a_presc = 8'($urandom); a_mode = 2'($urandom); a_en = 1'($urandom);
      a_valid = 1'($urandom); a_din = $urandom; t_en = 1'($urandom);
      t_valid = 1'($urandom); t_din = {$urandom, $urandom, $urandom};
    end
    chk("reset_hold_errs", 128'(errs), 128'(0));
    chk("reset_a", 128'({a_sclk, a_lrclk, a_sdata, a_fs, a_ur, a_ready}), 128'(6'b000001));
    chk("reset_t", 128'({t_sclk, t_lrclk, t_sdata, t_fs, t_ur, t_ready}), 128'(6'b000001));
    a_en = 0; t_en = 0; a_valid = 0; t_valid = 0; a_presc = 8'd2; a_mode = 2'b00;
    t_presc = 8'd0; t_mode = 2'b10;
    @(negedge clk);
    rst_n = 1'b1;
    sb_on = 1'b1;
    repeat (4) tick();
    chk("post_reset_a", 128'({a_sclk, a_lrclk, a_sdata, a_fs, a_ur, a_ready}), 128'(6'b000001));
    chk("post_reset_t", 128'({t_sclk, t_lrclk, t_sdata, t_fs, t_ur, t_ready}), 128'(6'b000001));

    // I2S, P=2, preloaded L=A55A R=8001
    drv_q.push_back(32'hA55A8001);
    tick(); tick();
    chk("preload_ready", 128'(a_ready), 128'(0));
    a_en = 1'b1;
    wait_fs(0, 4, "first_load");
    check_frame(0, 2, "i2s_f1", -1, 0, '0, 1'b0);
    tick(); check_frame(0, 2, "underrun_f2", -1, 0, '0, 1'b0);

    // Continuous valid with incrementing data; first transfer lands on a load edge
    stream = 1'b1;
    tick(); check_frame(0, 2, "same_cycle_f3", -1, 0, '0, 1'b0);
    tick(); check_frame(0, 2, "stream_f4", -1, 0, '0, 1'b0);
    a_mode = 2'b01; a_presc = 8'd0;
    tick(); check_frame(0, 1, "lj_p0_f5", -1, 0, '0, 1'b0);
    a_mode = 2'b11; a_presc = 8'd3;
    tick(); check_frame(0, 3, "rsv_f6", -1, 0, '0, 1'b0);
    a_mode = 2'b00; a_presc = 8'd2;
    tick(); check_frame(0, 2, "presc_chg_f7", 40, 4, '0, 1'b0);
    stream = 1'b0;
    tick(); check_frame(0, 4, "presc_new_f8", -1, 0, '0, 1'b0);

    // Truncate a frame with enable, then restart with a preloaded sample
    tick();
    chk("f9_start", 128'(a_fs), 128'(1));
    repeat (30) tick();
    a_en = 1'b0;
    tick();
    chk("disable_outs", 128'({a_sclk, a_lrclk, a_sdata}), 128'(0));
    repeat (3) tick();
    chk("disable_hold", 128'({a_sclk, a_lrclk, a_sdata, a_fs}), 128'(0));
    drv_q.push_back($urandom);
    a_presc = 8'd1; a_mode = 2'b01;
    tick(); tick();
    a_en = 1'b1;
    wait_fs(0, 4, "restart");
    check_frame(0, 1, "restart_f", -1, 0, '0, 1'b0);

    // TDM instance: 4 x 24-bit in 32-bit slots, prescaler 0
    t_din  = {$urandom, $urandom, $urandom};
    t_word = tdm_word(t_din);
    t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    tick();
    chk("tdm_preload_ready", 128'(t_ready), 128'(0));
    t_en = 1'b1;
    wait_fs(1, 4, "tdm_first");
    check_frame(1, 1, "tdm_f1", -1, 0, t_word, 1'b0);
    tick(); check_frame(1, 1, "tdm_f2", -1, 0, '0, 1'b1);
    t_en = 1'b0;

    // Asynchronous reset at bit 20 with a sample held
    a_presc = 8'd2; a_mode = 2'b00;
    wait_fs(0, 200, "rst_sync");
    drv_q.push_back($urandom);
    repeat (82) tick();
    chk("pre_rst_ready", 128'(a_ready), 128'(0));
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", 128'({a_sclk, a_lrclk, a_sdata, a_fs, a_ur, a_ready}), 128'(6'b000001));
    sb_on = 1'b0; exp_q.delete(); pend = 1'b0; a_valid = 1'b0; a_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_abort", 128'({a_sclk, a_lrclk, a_sdata, a_fs, a_ur, a_ready}), 128'(6'b000001));
    chk("ready_track_errs", 128'(rdy_errs), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
